// File: rtl/core_lsu_pkg.sv
// Shared types and helpers for the pipelined load/store unit: size codes,
// the per-request FIFO entry, and byte-lane strobe / data formatting helpers.
package core_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SZ_B = 2'd0,
        LSU_SZ_H = 2'd1,
        LSU_SZ_W = 2'd2,
        LSU_SZ_D = 2'd3
    } lsu_size_e;

    // discard is deliberately the LSB so the FIFO can mark it by bit position.
    typedef struct packed {
        logic [2:0] offset;
        lsu_size_e  size;
        logic       sext;
        logic       load;
        logic       discard;
    } lsu_entry_t;

    localparam int LSU_ENTRY_W = $bits(lsu_entry_t);

    function automatic logic [7:0] lsu_strb(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            LSU_SZ_B: m = 8'h01;
            LSU_SZ_H: m = 8'h03;
            LSU_SZ_W: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m << offset;
    endfunction

    function automatic logic [63:0] lsu_wrep(input logic [63:0] wd, input logic [1:0] size);
        case (size)
            LSU_SZ_B: return {8{wd[7:0]}};
            LSU_SZ_H: return {4{wd[15:0]}};
            LSU_SZ_W: return {2{wd[31:0]}};
            default:  return wd;
        endcase
    endfunction

    function automatic logic [63:0] lsu_rformat(input logic [63:0] rd, input logic [2:0] offset,
                                                input logic [1:0] size, input logic sext);
        logic [63:0] sh;
        sh = rd >> {offset, 3'b000};
        case (size)
            LSU_SZ_B: return sext ? {{56{sh[7]}}, sh[7:0]}   : {56'b0, sh[7:0]};
            LSU_SZ_H: return sext ? {{48{sh[15]}}, sh[15:0]} : {48'b0, sh[15:0]};
            LSU_SZ_W: return sext ? {{32{sh[31]}}, sh[31:0]} : {32'b0, sh[31:0]};
            default:  return sh;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_fifo.sv
// Synchronous FIFO of in-flight request descriptors with a bulk port that sets
// bit 0 (the discard flag) of every slot.
module core_lsu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_din,
    input  logic                         i_pop,
    input  logic                         i_mark_all,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;
    logic [W-1:0]  w_slots [DEPTH];

    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [W-1:0] r_slot;
            // Marking free slots too is harmless: a push overwrites the whole slot.
            always_ff @(posedge g_clk) begin
                if (!g_resetn)
                    r_slot <= '0;
                else if (w_push && (r_wptr == PW'(gi)))
                    r_slot <= i_din;
                else if (i_mark_all)
                    r_slot[0] <= 1'b1;
            end
            assign w_slots[gi] = r_slot;
        end
    endgenerate

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = w_slots[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/core_exec_lsu_q.sv
// Execute-stage load/store unit keeping up to DEPTH requests in flight on a
// split request/response memory bus, returning responses strictly in order.
module core_exec_lsu_q
    import core_lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              valid,
    output logic              ready,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              store,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic              flush,
    output logic              rsp_valid,
    output logic              rsp_load,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_trap_addr,
    output logic              rsp_trap_bus,
    output logic              dmem_req,
    output logic [XLEN-1:0]   dmem_addr,
    output logic              dmem_wen,
    output logic [XLEN/8-1:0] dmem_strb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rsp_valid,
    input  logic              dmem_err,
    input  logic [XLEN-1:0]   dmem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] w_count;
    lsu_entry_t    w_head, w_entry;
    logic          w_misalign, w_trap_acc, w_push, w_pop, w_head_live;
    logic [2:0]    w_offset;
    logic [7:0]    w_strb8;
    logic [63:0]   w_wrep, w_fmt;

    logic            r_rsp_valid, r_rsp_load, r_rsp_trap_addr, r_rsp_trap_bus;
    logic [XLEN-1:0] r_rsp_rdata;

    assign w_offset = 3'(addr[OW-1:0]);

    always_comb begin
        case (size)
            LSU_SZ_B: w_misalign = 1'b0;
            LSU_SZ_H: w_misalign = addr[0];
            LSU_SZ_W: w_misalign = |addr[1:0];
            default:  w_misalign = (XLEN == 32) || (|addr[2:0]);
        endcase
    end

    // Misaligned requests never reach memory; they wait for an empty queue so
    // their trap response cannot overtake older memory responses.
    assign dmem_req    = valid && !flush && !w_misalign && (w_count < CW'(DEPTH));
    assign w_trap_acc  = valid && !flush && w_misalign && (w_count == '0);
    assign w_push      = dmem_req && dmem_gnt;
    assign ready       = w_misalign ? w_trap_acc : w_push;
    assign w_pop       = dmem_rsp_valid && (w_count != '0);
    assign w_head_live = w_pop && !w_head.discard && !flush;

    assign dmem_addr  = {addr[XLEN-1:OW], {OW{1'b0}}};
    assign dmem_wen   = store;
    assign w_strb8    = lsu_strb(size, w_offset);
    assign dmem_strb  = w_strb8[NB-1:0];
    assign w_wrep     = lsu_wrep(64'(wdata), size);
    assign dmem_wdata = w_wrep[XLEN-1:0];
    assign w_fmt      = lsu_rformat(64'(dmem_rdata), w_head.offset, w_head.size, w_head.sext);

    always_comb begin
        w_entry         = '0;
        w_entry.offset  = w_offset;
        w_entry.size    = lsu_size_e'(size);
        w_entry.sext    = sext;
        w_entry.load    = !store;
        w_entry.discard = 1'b0;
    end

    core_lsu_fifo #(.DEPTH(DEPTH), .W(LSU_ENTRY_W)) u_fifo (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .i_push     (w_push),
        .i_din      (w_entry),
        .i_pop      (w_pop),
        .i_mark_all (flush),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_load      <= 1'b0;
            r_rsp_trap_addr <= 1'b0;
            r_rsp_trap_bus  <= 1'b0;
            r_rsp_rdata     <= '0;
        end else begin
            r_rsp_valid     <= w_trap_acc || w_head_live;
            r_rsp_load      <= w_trap_acc ? !store : (w_head_live && w_head.load);
            r_rsp_trap_addr <= w_trap_acc;
            r_rsp_trap_bus  <= w_head_live && dmem_err;
            r_rsp_rdata     <= (w_head_live && w_head.load && !dmem_err) ? w_fmt[XLEN-1:0] : '0;
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_load      = r_rsp_load;
    assign rsp_trap_addr = r_rsp_trap_addr;
    assign rsp_trap_bus  = r_rsp_trap_bus;
    assign rsp_rdata     = r_rsp_rdata;

    // A memory response with nothing outstanding is a bus protocol violation.
    a_no_orphan_rsp: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(dmem_rsp_valid && (w_count == '0)));

endmodule

// File: tb/tb_core_exec_lsu_q.sv
// Directed bench for core_exec_lsu_q with a queue-based reference model and
// per-cycle output comparison, plus literal expectations from the test plan.
module tb_core_exec_lsu_q;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            g_clk = 1'b0;
    logic            g_resetn, valid, store, sext, flush;
    logic            dmem_gnt, dmem_rsp_valid, dmem_err;
    logic [1:0]      size;
    logic [XLEN-1:0] addr, wdata, dmem_rdata;
    logic            ready, rsp_valid, rsp_load, rsp_trap_addr, rsp_trap_bus;
    logic            dmem_req, dmem_wen;
    logic [XLEN-1:0] rsp_rdata, dmem_addr, dmem_wdata;
    logic [XLEN/8-1:0] dmem_strb;

    always #5 g_clk = ~g_clk;

    core_exec_lsu_q #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .ready(ready),
        .addr(addr), .wdata(wdata), .store(store), .size(size), .sext(sext),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_load(rsp_load),
        .rsp_rdata(rsp_rdata), .rsp_trap_addr(rsp_trap_addr),
        .rsp_trap_bus(rsp_trap_bus), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned off;
        int unsigned sz;
        bit          sx;
        bit          ld;
        bit          disc;
    } mentry_t;

    mentry_t     mq[$];
    mentry_t     m_h;
    int          m_n;
    bit          e_v, e_load, e_ta, e_tb;
    logic [63:0] e_rdata;

    function automatic bit m_misal(input logic [63:0] a, input logic [1:0] s);
        return ((a % (64'd1 << s)) != 0) || (s == 2'd3 && XLEN == 32);
    endfunction

    function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] s);
        logic [7:0] r;
        int off, nb;
        off = int'(a % 8);
        nb  = 1 << s;
        for (int i = 0; i < 8; i++) r[i] = (i >= off) && (i < off + nb);
        return r;
    endfunction

    function automatic logic [63:0] m_wrep(input logic [63:0] wd, input logic [1:0] s);
        logic [63:0] r;
        int nb;
        nb = 1 << s;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_fmt(input logic [63:0] rd, input int unsigned off,
                                          input int unsigned s, input bit sx);
        logic [63:0] v, mask;
        int bits;
        v    = rd >> (off * 8);
        bits = 8 << s;
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v    = v & mask;
            if (sx && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(posedge g_clk) begin
        e_v = 0; e_load = 0; e_ta = 0; e_tb = 0; e_rdata = '0;
        if (!g_resetn) begin
            mq.delete();
        end else begin
            m_n = mq.size();
            if (dmem_rsp_valid && m_n > 0) begin
                m_h = mq.pop_front();
                if (!m_h.disc && !flush) begin
                    e_v     = 1;
                    e_load  = m_h.ld;
                    e_tb    = dmem_err;
                    e_rdata = (m_h.ld && !dmem_err) ? m_fmt(dmem_rdata, m_h.off, m_h.sz, m_h.sx) : 64'd0;
                end
            end
            if (flush) foreach (mq[i]) mq[i].disc = 1;
            if (valid && !flush && m_misal(addr, size) && m_n == 0) begin
                e_v = 1; e_ta = 1; e_load = !store;
            end
            if (valid && !flush && !m_misal(addr, size) && m_n < DEPTH && dmem_gnt)
                mq.push_back('{off: int'(addr % 8), sz: int'(size), sx: sext, ld: !store, disc: 0});
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge g_clk) begin
        bit mis, xreq, xrdy;
        mis  = m_misal(addr, size);
        xreq = valid && !flush && !mis && (mq.size() < DEPTH);
        xrdy = mis ? (valid && !flush && mq.size() == 0) : (xreq && dmem_gnt);
        chk("dmem_req", dmem_req, xreq);
        chk("ready", ready, xrdy);
        if (xreq) begin
            chk("dmem_addr", dmem_addr, addr & ~64'd7);
            chk("dmem_strb", dmem_strb, m_strb(addr, size));
            chk("dmem_wdata", dmem_wdata, m_wrep(wdata, size));
            chk("dmem_wen", dmem_wen, store);
        end
        chk("rsp_valid", rsp_valid, e_v);
        chk("rsp_load", rsp_load, e_load);
        chk("rsp_trap_addr", rsp_trap_addr, e_ta);
        chk("rsp_trap_bus", rsp_trap_bus, e_tb);
        chk("rsp_rdata", rsp_rdata, e_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a, input logic [1:0] s, input bit st,
                       input bit sx, input logic [63:0] wd);
        valid = 1; addr = a; size = s; store = st; sext = sx; wdata = wd;
    endtask

    task automatic mrsp(input bit v, input logic [63:0] d, input bit e);
        dmem_rsp_valid = v; dmem_rdata = d; dmem_err = e;
    endtask

    initial begin
        g_resetn = 0; valid = 0; store = 0; sext = 0; flush = 0; size = 0;
        addr = '0; wdata = '0; dmem_gnt = 1; dmem_rsp_valid = 0; dmem_err = 0;
        dmem_rdata = '0;
        step(); step();
        g_resetn = 1;
        @(negedge g_clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset dmem_req", dmem_req, 0);

        // Sign-extended word load
        step(); req(64'h1004, 2'd2, 0, 1, 64'h0);
        @(negedge g_clk);
        chk("lw dmem_addr", dmem_addr, 64'h1000);
        chk("lw strb", dmem_strb, 8'hF0);
        step(); valid = 0;
        step(); mrsp(1, 64'h80000001_00000000, 0);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk);
        chk("lw rsp_valid", rsp_valid, 1);
        chk("lw rsp_load", rsp_load, 1);
        chk("lw rsp_rdata", rsp_rdata, 64'hFFFFFFFF_80000001);

        // Misaligned halfword store
        step(); req(64'h1003, 2'd1, 1, 0, 64'h1234);
        @(negedge g_clk);
        chk("sh_mis dmem_req", dmem_req, 0);
        step(); valid = 0;
        @(negedge g_clk);
        chk("sh_mis rsp_valid", rsp_valid, 1);
        chk("sh_mis trap_addr", rsp_trap_addr, 1);
        chk("sh_mis rsp_rdata", rsp_rdata, 64'h0);

        // Byte store with bus error
        step(); req(64'h2007, 2'd0, 1, 0, 64'hAB);
        @(negedge g_clk);
        chk("sb strb", dmem_strb, 8'h80);
        chk("sb wdata", dmem_wdata, 64'hABABABABABABABAB);
        step(); valid = 0;
        step(); mrsp(1, 64'h1234, 1);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk);
        chk("sb trap_bus", rsp_trap_bus, 1);
        chk("sb rsp_load", rsp_load, 0);

        // Back-pressure at full
        step(); req(64'h3000, 2'd3, 0, 0, 64'h0);
        @(negedge g_clk); chk("bp ready0", ready, 1);
        step(); req(64'h3008, 2'd2, 0, 0, 64'h0);
        @(negedge g_clk); chk("bp ready1", ready, 1);
        step(); req(64'h3012, 2'd1, 0, 1, 64'h0);
        @(negedge g_clk); chk("bp ready2 full", ready, 0);
        step(); mrsp(1, 64'h01234567_89ABCDEF, 0);
        @(negedge g_clk); chk("bp ready2 pop", ready, 0);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk);
        chk("bp ready2 after", ready, 1);
        chk("bp rsp0", rsp_rdata, 64'h01234567_89ABCDEF);
        step(); valid = 0; mrsp(1, 64'hDEADBEEF_CAFEF00D, 0);
        step(); mrsp(1, 64'h00000000_80010000, 0);
        @(negedge g_clk); chk("bp rsp1", rsp_rdata, 64'h00000000_CAFEF00D);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk); chk("bp rsp2", rsp_rdata, 64'hFFFFFFFF_FFFF8001);

        // Flush with two outstanding loads
        step(); req(64'h4000, 2'd3, 0, 0, 64'h0);
        step(); req(64'h4008, 2'd3, 0, 0, 64'h0);
        step(); valid = 0; flush = 1;
        step(); flush = 0; mrsp(1, 64'h1111, 0);
        step(); mrsp(1, 64'h2222, 0);
        @(negedge g_clk); chk("flush rsp_valid a", rsp_valid, 0);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk); chk("flush rsp_valid b", rsp_valid, 0);
        step(); flush = 1; req(64'h5004, 2'd2, 0, 0, 64'h0);
        @(negedge g_clk);
        chk("flush dmem_req", dmem_req, 0);
        chk("flush ready", ready, 0);
        step(); flush = 0;
        @(negedge g_clk); chk("postflush ready", ready, 1);
        step(); valid = 0;
        step(); mrsp(1, 64'h11223344_55667788, 0);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk);
        chk("postflush rsp_valid", rsp_valid, 1);
        chk("postflush rsp_rdata", rsp_rdata, 64'h00000000_11223344);
        // Flush in the same cycle as the pop
        step(); req(64'h4010, 2'd3, 0, 0, 64'h0);
        step(); valid = 0; flush = 1; mrsp(1, 64'h3333, 0);
        step(); flush = 0; mrsp(0, 64'h0, 0);
        @(negedge g_clk); chk("flushpop rsp_valid", rsp_valid, 0);

        // Reset with two outstanding
        step(); req(64'h6000, 2'd3, 0, 0, 64'h0);
        step(); req(64'h6008, 2'd3, 0, 0, 64'h0);
        step(); valid = 0; g_resetn = 0;
        step(); g_resetn = 1;
        @(negedge g_clk); chk("rst rsp_valid", rsp_valid, 0);
        step(); req(64'h6010, 2'd0, 0, 1, 64'h0);
        @(negedge g_clk); chk("rst ready first", ready, 1);
        step(); req(64'h6021, 2'd0, 0, 0, 64'h0);
        @(negedge g_clk); chk("rst ready second", ready, 1);
        step(); valid = 0; mrsp(1, 64'h00000000_000000FF, 0);
        step(); mrsp(1, 64'h00000000_0000AB00, 0);
        @(negedge g_clk); chk("rst rsp a", rsp_rdata, 64'hFFFFFFFF_FFFFFFFF);
        step(); mrsp(0, 64'h0, 0);
        @(negedge g_clk); chk("rst rsp b", rsp_rdata, 64'h00000000_000000AB);

        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
